// File: rtl/fetch_seq_if.sv
// fetch_seq_if: fetch-side bus bundle
// Groups the instruction-memory request/response channel, the decode
// handshake, the execute redirect and the halt flag.
// master: fetch_seq side, slave: memory/decode/execute side.
interface fetch_seq_if #(parameter int XLEN = 32);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_inst;
    logic [XLEN-1:0] id_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            halt_o;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc, halt_o,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc, halt_o,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: single-outstanding instruction fetch sequencer feeding decode
// Ports: clk, rst_n (async active-low), bus (fetch_seq_if.master):
//   imem_req_*  request channel, imem_rsp_* response, id_* decode handshake,
//   redirect_* control-flow change, halt_o halt flag.
// Optional: FETCH_EBREAK_HALT_EN adds a terminal HALT after an ebreak is consumed.
module fetch_seq #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_seq_if.master bus
);
`ifdef FETCH_EBREAK_HALT_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP, HALT} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;
`endif

    state_t          state, nxt;
    logic [XLEN-1:0] pc_q, id_inst_q, id_pc_q;
    logic            id_valid_q, redir, cap, ack;

`ifdef FETCH_EBREAK_HALT_EN
    logic halt_q;
    // once halted, redirects no longer reach the fetch state
    assign redir = bus.redirect_valid && state != HALT;
`else
    assign redir = bus.redirect_valid;
`endif
    assign cap = state == WAIT && bus.imem_rsp_valid && !redir;
    assign ack = state == HOLD && bus.id_ready;

    assign bus.imem_req_valid = state == REQ;
    assign bus.imem_req_addr  = pc_q;
    assign bus.id_valid       = id_valid_q;
    assign bus.id_inst        = id_inst_q;
    assign bus.id_pc          = id_pc_q;

    // an accepted request under redirect still owes a response, hence DROP
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = REQ;
            REQ:  nxt = bus.imem_req_ready ? (redir ? DROP : WAIT) : REQ;
            WAIT: nxt = bus.imem_rsp_valid ? (redir ? REQ : HOLD) : (redir ? DROP : WAIT);
`ifdef FETCH_EBREAK_HALT_EN
            HOLD: nxt = redir ? REQ : !bus.id_ready ? HOLD : halt_q ? HALT : REQ;
`else
            HOLD: nxt = (redir || bus.id_ready) ? REQ : HOLD;
`endif
            DROP: nxt = bus.imem_rsp_valid ? REQ : DROP;
            default: nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_inst_q  <= '0;
            id_pc_q    <= '0;
        end else begin
            state <= nxt;
            if (redir)
                pc_q <= bus.redirect_pc & ~XLEN'(3);
            else if (cap)
                pc_q <= pc_q + XLEN'(4);
            if (redir || ack)
                id_valid_q <= 1'b0;
            else if (cap)
                id_valid_q <= 1'b1;
            if (cap) begin
                id_inst_q <= bus.imem_rsp_data;
                id_pc_q   <= pc_q;
            end
        end
    end

`ifdef FETCH_EBREAK_HALT_EN
    // raised with id_valid for a captured ebreak; a redirect in HOLD discards it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            halt_q <= 1'b0;
        else if (cap)
            halt_q <= bus.imem_rsp_data == XLEN'(32'h0010_0073);
        else if (redir)
            halt_q <= 1'b0;
    end
    assign bus.halt_o = halt_q;
`else
    assign bus.halt_o = 1'b0;
`endif
endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Sequences instruction fetch for the decode stage.
- Issues one instruction-memory request at a time over a valid/ready handshake.
- Captures the response into an output register and presents instruction + PC to the decoder with a valid/ready handshake.
- Handles control-flow redirects from execute, discarding any in-flight stale response.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
XLEN, 32, width of PC and instruction

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = in reset)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  XLEN  fetch address, word aligned
imem_rsp_valid  in  1  response data valid (exactly one per accepted request)
imem_rsp_data  in  XLEN  fetched instruction
id_valid  out  1  instruction available to decoder
id_ready  in  1  decoder consumes instruction this cycle
id_inst  out  XLEN  instruction to decoder
id_pc  out  XLEN  PC of id_inst
redirect_valid  in  1  control-flow change
redirect_pc  in  XLEN  new fetch PC
halt_o  out  1  fetch halted (optional feature only; constant 0 otherwise)

Behaviour:
- Reset (rst=0, async): state=IDLE, pc_q=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_inst=0, id_pc=0, halt_o=0.
- States: IDLE, REQ, WAIT, HOLD, DROP.
- IDLE:
  - One cycle after reset release, then REQ.
  - A redirect in IDLE loads pc_q and still goes to REQ.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc_q.
  - Address held stable until req_ready, except on redirect.
  - req_ready=1 -> WAIT.
- WAIT:
  - On rsp_valid: id_inst<=rsp_data, id_pc<=pc_q, id_valid<=1, pc_q<=pc_q+4, go HOLD.
- HOLD:
  - id_valid=1; id_inst/id_pc stable while id_ready=0.
  - On id_ready: id_valid<=0 and go REQ, so the next request is issued the following cycle.
- DROP:
  - Waits for the pending response; rsp_valid -> discard, go REQ.
- Redirect has priority over all other events in every state:
  - pc_q<=redirect_pc & ~32'h3 (low two bits forced 0).
  - id_valid<=0.
- Redirect, by state:
  - REQ with req_ready=0: stay REQ; the new address appears next cycle.
  - REQ with req_ready=1 in the same cycle: the request counts as accepted; go DROP.
  - WAIT without rsp_valid: go DROP.
  - WAIT with rsp_valid in the same cycle: discard the data; go REQ.
  - HOLD: go REQ, even if id_ready=1 the same cycle. The decoder handshake completes, but execute has already redirected.
  - DROP without rsp_valid: update pc_q; stay DROP.
  - DROP with rsp_valid: update pc_q; go REQ.
- pc arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 -> 32'h0000_0000.
- rsp_valid outside WAIT/DROP is ignored (protocol violation; no state change).
- Latency, with ready=1 and response one cycle after acceptance:
  - Reset release at cycle 0, IDLE.
  - Cycle 1: req issued.
  - Cycle 2: rsp.
  - Cycle 3: id_valid=1.
  - Steady state: one instruction per 3 cycles.
- At most one outstanding request at any time.

Optional Feature:
FETCH_EBREAK_HALT_EN
- Defined:
  - When an instruction equal to 32'h0010_0073 (ebreak) is captured into id_inst, halt_o<=1 one cycle later, together with id_valid.
  - After that instruction's decoder handshake the block enters a terminal HALT state: no further requests, id_valid=0.
  - Only reset clears HALT; redirect does not exit it.
- Undefined: halt_o tied 0, the HALT state is absent, and ebreak is delivered like any other instruction.

Test Plan:
- Reset, then imem always ready, rsp 1 cycle later with data=32'h0000_0013 -> req addr 80000000 at cycle 1, id_valid=1 at cycle 3 with id_pc=80000000; next req addr 80000004.
- Hold id_ready=0 for 5 cycles in HOLD -> id_inst/id_pc stable, no new imem_req_valid; id_ready=1 -> id_valid drops next cycle, req for pc+4 the following cycle.
- Redirect to 32'h8000_0103 while in WAIT; rsp arrives 2 cycles later -> response discarded, id_valid never asserts for it, next req addr 80000100.
- Redirect the same cycle as rsp_valid in WAIT -> data dropped, REQ next cycle at the redirect address; redirect in REQ with req_ready=0 -> addr changes next cycle without a gap.
- RESET_PC=32'hFFFF_FFFC -> second fetch addr 32'h0000_0000; assert rst low mid-WAIT -> all outputs return to reset values immediately, fetch restarts at RESET_PC.
- With FETCH_EBREAK_HALT_EN: fetch 32'h0010_0073 -> halt_o=1 with id_valid; after the handshake no further imem_req_valid; redirect ignored.
